inst_rom_responder: RTL and testbench
=====================================

// Module: inst_rom_responder
// PURPOSE
//   Instruction-memory model that answers fetch requests with a request / dataOk handshake.
//   It sits directly upstream of one fetch way (one instance per way): it takes instAddr,
//   reads a preloaded word array after a fixed latency, and returns the word on inst_o / dataOk_o.
//   Supports up to QDEPTH outstanding requests, consumer back-pressure, and a flush on redirect.
// PARAMETERS
//   DEPTH_WORDS  1024          number of 32-bit words in the array; must be a power of 2
//   LATENCY      2             cycles from request acceptance to earliest dataOk_o; 1..4
//   QDEPTH       4             max requests in flight plus buffered; power of 2, >= LATENCY
//   INIT_FILE    "inst.hex"    $readmemh image loaded at elaboration
// PORTS
//   clk          in   1   single clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   request_i    in   1   fetch request valid
//   instAddr_i   in   32  byte address of the requested instruction
//   ready_o      out  1   a request is accepted on a cycle with request_i && ready_o
//   flush_i      in   1   redirect: discard every in-flight and buffered response
//   inst_o       out  32  instruction word; valid only while dataOk_o is high
//   dataOk_o     out  1   response valid; held until ack_i
//   err_o        out  1   qualifies inst_o: misaligned or out-of-range address
//   ack_i        in   1   consumer takes the response on a cycle with dataOk_o && ack_i
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - Reset values: ready_o=1, dataOk_o=0, err_o=0, inst_o=0. All pipe valids and the FIFO are cleared.
//   - Word index = instAddr_i[$clog2(DEPTH_WORDS)+1:2].
//     - Misaligned address (instAddr_i[1:0]!=0): return inst 32'h0000_0013 (NOP), err=1.
//     - Out of range (any bit above the index field set): return NOP, err=1.
//   - Pipeline is LATENCY stages of {valid, word, err}; the array read happens in stage 0.
//     Stage LATENCY-1 writes into the response FIFO (inst_resp_fifo, QDEPTH entries).
//   - Credit counter `occ` = in-flight + FIFO count, width $clog2(QDEPTH)+1.
//     - ready_o = (occ < QDEPTH), combinational from registered occ.
//     - occ +1 on accept, -1 on pop; accept and pop in the same cycle leave occ unchanged.
//   - Because of the credit counter, the FIFO never overflows; no drop path exists.
//   - Latency: a request accepted in cycle t with an empty FIFO gives dataOk_o=1 in cycle t+LATENCY.
//   - Ordering: responses return strictly in request order.
//   - dataOk_o = FIFO non-empty; inst_o/err_o come from the FIFO head.
//     - inst_o/err_o stay stable while dataOk_o && !ack_i.
//     - ack_i while dataOk_o=0 is ignored.
//   - Back-to-back: with ack_i held high, one response per cycle at full throughput.
//   - flush_i (synchronous):
//     - On the next edge, clear all pipe valids and the FIFO and set occ=0.
//     - dataOk_o=0 from the next cycle onward.
//     - A request_i presented in the flush cycle IS accepted (it is the redirect target);
//       occ becomes 1 and its response appears LATENCY cycles later.
//     - ack_i in the flush cycle is a don't-care.
//   - Reset mid-operation: everything is discarded immediately (asynchronous); no response survives.
//   - No state machine beyond the pipe valids and the credit counter; occ wraps never (bounded by QDEPTH).
// STRUCTURE
//   - Shared package b8_fetch_pkg:
//     - INST_W=32, ADDR_W=32
//     - NOP_INST=32'h0000_0013
//     - typedef rom_resp_t {logic [31:0] inst; logic err;}
//   - Sub-module inst_resp_fifo (sync FIFO, WIDTH=33, DEPTH=QDEPTH).
//     - Ports: push, pop, flush, full, empty, data in/out.
//     - Count bit on the pointers for full/empty.
//   - Top level holds the array, the LATENCY pipe, the occ counter, and the ready logic.
// TESTING
//   1. Reset: load mem[0..3]=32'h11,22,33,44; hold reset 3 cycles -> ready_o=1, dataOk_o=0, err_o=0.
//   2. Single request, LATENCY=2: request addr 0x8 at t0, ack_i=1 ->
//      dataOk_o=1, inst_o=32'h33 at t2 only.
//   3. Streaming: request 0x0,0x4,0x8,0xC on consecutive cycles, ack_i=1 ->
//      inst 11,22,33,44 on 4 consecutive cycles.
//   4. Back-pressure: ack_i=0, request every cycle ->
//      exactly QDEPTH=4 accepted, ready_o=0 afterwards.
//      Then assert ack_i for 1 cycle -> ready_o=1 next cycle, order preserved.
//   5. Flush: 3 outstanding, then flush_i with request_i at addr 0x4 in the same cycle ->
//      next cycle dataOk_o=0; only inst 32'h22 is returned, LATENCY cycles after the flush.
//   6. Errors: addr 0x6 -> inst_o=32'h13, err_o=1.
//      addr 4*DEPTH_WORDS -> inst_o=32'h13, err_o=1.
//   7. Reset asserted with 2 in flight -> outputs go to reset values asynchronously;
//      no dataOk_o after release.

Source files
------------

// File: rtl/b8_fetch_pkg.sv
// Shared fetch-side types and constants for the instruction ROM responder.
package b8_fetch_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic              err;
   } rom_resp_t;

   typedef struct packed {
      logic      valid;
      rom_resp_t resp;
   } pipe_stage_t;

endpackage

// File: rtl/inst_resp_fifo.sv
// Synchronous response FIFO; pointers carry an extra wrap bit for full/empty.
module inst_resp_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A push coinciding with flush lands in slot 0 of the freshly emptied FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= push_i ? (AW+1)'(1) : '0;
      end else begin
         if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && (flush_i || !full_o))
         mem_q[flush_i ? '0 : wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/inst_rom_responder.sv
// Instruction ROM model: fixed-latency read pipe, credit-limited response FIFO, flush on redirect.
module inst_rom_responder #(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    LATENCY     = 2,
   parameter int    QDEPTH      = 4,
   parameter string INIT_FILE   = "inst.hex"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        request_i,
   input  logic [31:0] instAddr_i,
   output logic        ready_o,
   input  logic        flush_i,
   output logic [31:0] inst_o,
   output logic        dataOk_o,
   output logic        err_o,
   input  logic        ack_i
);
   import b8_fetch_pkg::*;

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int OCC_W = $clog2(QDEPTH) + 1;
   localparam int NREG  = (LATENCY > 1) ? LATENCY - 1 : 1;

   // Preloaded image; contents come from INIT_FILE or are placed by the environment.
   logic [INST_W-1:0] rom_mem [DEPTH_WORDS];

   logic [OCC_W-1:0] occ_q, occ_d;
   pipe_stage_t      pipe_q [NREG];
   pipe_stage_t      stage0, push_src;
   rom_resp_t        head;
   logic             accept, pop, fifo_push, fifo_full, fifo_empty;

   assign ready_o = (occ_q < OCC_W'(QDEPTH));
   assign accept  = request_i && ready_o;
   assign pop     = !fifo_empty && ack_i;

   // Stage 0 is the request cycle itself, so the array read is combinational here.
   always_comb begin
      stage0.valid    = accept;
      stage0.resp.err = (instAddr_i[1:0] != 2'b00) || (|instAddr_i[ADDR_W-1:IDX_W+2]);
      stage0.resp.inst = stage0.resp.err ? NOP_INST : rom_mem[instAddr_i[IDX_W+1:2]];
   end

   always_comb begin
      occ_d = occ_q;
      if (flush_i)
         occ_d = accept ? OCC_W'(1) : '0;
      else if (accept && !pop)
         occ_d = occ_q + OCC_W'(1);
      else if (!accept && pop)
         occ_d = occ_q - OCC_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_q <= '0;
         for (int i = 0; i < NREG; i++) pipe_q[i] <= '0;
      end else begin
         occ_q     <= occ_d;
         pipe_q[0] <= stage0;
         for (int i = 1; i < NREG; i++) pipe_q[i] <= flush_i ? '0 : pipe_q[i-1];
      end
   end

   // Only the redirect target may enter on a flush cycle; with LATENCY=1 it pushes directly.
   assign push_src  = (LATENCY == 1) ? stage0 : pipe_q[NREG-1];
   assign fifo_push = push_src.valid && (flush_i ? (LATENCY == 1) : !fifo_full);

   inst_resp_fifo #(
      .WIDTH ($bits(rom_resp_t)),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .pop_i   (pop),
      .flush_i (flush_i),
      .data_i  (push_src.resp),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign dataOk_o = !fifo_empty;
   assign inst_o   = fifo_empty ? '0 : head.inst;
   assign err_o    = !fifo_empty && head.err;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench for inst_rom_responder (LATENCY=2, QDEPTH=4, DEPTH_WORDS=1024).
module tb_inst_rom_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        request_i;
   logic [31:0] instAddr_i;
   logic        ready_o;
   logic        flush_i;
   logic [31:0] inst_o;
   logic        dataOk_o;
   logic        err_o;
   logic        ack_i;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] exp_q[$];

   inst_rom_responder #(
      .DEPTH_WORDS (1024),
      .LATENCY     (2),
      .QDEPTH      (4),
      .INIT_FILE   ("inst.hex")
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .request_i  (request_i),
      .instAddr_i (instAddr_i),
      .ready_o    (ready_o),
      .flush_i    (flush_i),
      .inst_o     (inst_o),
      .dataOk_o   (dataOk_o),
      .err_o      (err_o),
      .ack_i      (ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   // Outputs are sampled and inputs changed on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input logic req, input logic [31:0] addr);
      request_i  = req;
      instAddr_i = addr;
   endtask

   initial begin
      reset = 1'b1; request_i = 1'b0; instAddr_i = '0; flush_i = 1'b0; ack_i = 1'b0;
      dut.rom_mem[0]    = 32'h11;
      dut.rom_mem[1]    = 32'h22;
      dut.rom_mem[2]    = 32'h33;
      dut.rom_mem[3]    = 32'h44;
      dut.rom_mem[1023] = 32'hDEAD_BEEF;

      // Reset values
      repeat (3) cyc();
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_dataok", 32'(dataOk_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_inst", inst_o, 32'h0);
      reset = 1'b0;
      cyc();

      // Single request, response only in t0+2
      ack_i = 1'b1;
      drive(1'b1, 32'h8);
      cyc(); chk("single_t1_dataok", 32'(dataOk_o), 32'd0); drive(1'b0, 32'h0);
      cyc(); chk("single_t2_dataok", 32'(dataOk_o), 32'd1); chk("single_t2_inst", inst_o, 32'h33);
      cyc(); chk("single_t3_dataok", 32'(dataOk_o), 32'd0);

      // Streaming four words with ack held
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 8; i++) begin
         if (i >= 2 && i < 6) begin
            chk("stream_dataok", 32'(dataOk_o), 32'd1);
            chk("stream_inst", inst_o, exp_q.pop_front());
         end else if (i > 0) begin
            chk("stream_idle", 32'(dataOk_o), 32'd0);
         end
         drive(i < 4, 32'(4 * i));
         cyc();
      end

      // Back-pressure: exactly four accepted, head held stable
      ack_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("bp_ready", 32'(ready_o), (i < 4) ? 32'd1 : 32'd0);
         if (i >= 2) chk("bp_hold_inst", inst_o, 32'h11);
         drive(1'b1, 32'(4 * (i % 4)));
         cyc();
      end
      drive(1'b0, 32'h0);
      chk("bp_full_ready", 32'(ready_o), 32'd0);
      chk("bp_head", inst_o, 32'h11);
      ack_i = 1'b1;
      cyc(); chk("bp_ready_after_pop", 32'(ready_o), 32'd1);
      exp_q = '{32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 3; i++) begin
         chk("bp_order_dataok", 32'(dataOk_o), 32'd1);
         chk("bp_order_inst", inst_o, exp_q.pop_front());
         cyc();
      end
      chk("bp_drained", 32'(dataOk_o), 32'd0);
      ack_i = 1'b0;

      // Flush with redirect request in the flush cycle
      drive(1'b1, 32'h0);  cyc();
      drive(1'b1, 32'h8);  cyc();
      drive(1'b1, 32'hC);  cyc();
      chk("fl_pre_dataok", 32'(dataOk_o), 32'd1);
      chk("fl_pre_inst", inst_o, 32'h11);
      drive(1'b1, 32'h4); flush_i = 1'b1;
      cyc();
      flush_i = 1'b0; drive(1'b0, 32'h0);
      chk("fl_next_dataok", 32'(dataOk_o), 32'd0);
      chk("fl_next_ready", 32'(ready_o), 32'd1);
      cyc();
      chk("fl_target_dataok", 32'(dataOk_o), 32'd1);
      chk("fl_target_inst", inst_o, 32'h22);
      ack_i = 1'b1;
      cyc();
      chk("fl_only_one", 32'(dataOk_o), 32'd0);

      // Error addresses and the last valid word
      drive(1'b1, 32'h6);    cyc();
      drive(1'b1, 32'h1000); cyc();
      chk("err_mis_inst", inst_o, 32'h13); chk("err_mis_flag", 32'(err_o), 32'd1);
      drive(1'b1, 32'hFFC);  cyc();
      chk("err_oor_inst", inst_o, 32'h13); chk("err_oor_flag", 32'(err_o), 32'd1);
      drive(1'b0, 32'h0);    cyc();
      chk("last_word_inst", inst_o, 32'hDEAD_BEEF); chk("last_word_err", 32'(err_o), 32'd0);
      cyc();
      chk("err_idle_dataok", 32'(dataOk_o), 32'd0); chk("err_idle_err", 32'(err_o), 32'd0);

      // Asynchronous reset with two in flight
      ack_i = 1'b0;
      drive(1'b1, 32'h0); cyc();
      drive(1'b1, 32'h4); cyc();
      drive(1'b0, 32'h0); cyc();
      chk("ar_pre_dataok", 32'(dataOk_o), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("ar_dataok", 32'(dataOk_o), 32'd0);
      chk("ar_ready", 32'(ready_o), 32'd1);
      chk("ar_inst", inst_o, 32'h0);
      chk("ar_err", 32'(err_o), 32'd0);
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("ar_no_resp", 32'(dataOk_o), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
